// File: rtl/code_checker_if.sv
// Signal bundle between the keypad controller and the code checker.
// The controller drives key strobes and compare commands; the checker returns results and lengths.
interface code_checker_if;
    logic [3:0] button;
    logic       button_valid;
    logic       read_input;
    logic       check_uc;
    logic       check_pc;
    logic       latch_new;
    logic       check_match;
    logic       store;
    logic       data_ready;
    logic       correct_input;
    logic       validLength;
    logic       validLengthPC;
    logic [1:0] fsm_state;

    // Strobes (button_valid, check_*, latch_new, store) are single-cycle and have no ready.
    // data_ready qualifies correct_input and stays high until read_input rises or a new compare starts.
    modport master (
        output button, button_valid, read_input, check_uc, check_pc,
               latch_new, check_match, store,
        input  data_ready, correct_input, validLength, validLengthPC, fsm_state
    );

    modport slave (
        input  button, button_valid, read_input, check_uc, check_pc,
               latch_new, check_match, store,
        output data_ready, correct_input, validLength, validLengthPC, fsm_state
    );
endinterface

// File: rtl/code_checker.sv
// Keypad code checker: 6-digit entry buffer, user/candidate code registers and a
// three-state compare engine for user code, programming code and re-entry match.
module code_checker #(
    parameter logic [15:0] DEFAULT_UC = 16'h1234,
    parameter logic [23:0] PROG_CODE  = 24'h654321
) (
    input logic          hwclk,
    input logic          rst,
    code_checker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] entry_q, entry_d;
    logic [2:0]  count_q, count_d;
    logic        read_q;
    logic [15:0] uc_q;
    logic [15:0] cand_q;
    logic [23:0] op_q, op_d;
    logic        is_pc_q, is_pc_d;
    logic        result_q, result_d;

    logic        read_rise;
    logic        accept;
    logic        any_pulse;
    logic [23:0] sel_op;
    logic        sel_pc;

    assign read_rise = bus.read_input & ~read_q;
    assign accept    = bus.button_valid & bus.read_input & (bus.button <= 4'd6) & ~read_rise;
    assign any_pulse = bus.check_pc | bus.check_uc | bus.check_match;

    // Operand is snapshotted at the pulse so a same-cycle store cannot alter it.
    always_comb begin
        sel_op = {8'h00, cand_q};
        sel_pc = 1'b0;
        if (bus.check_pc) begin
            sel_op = PROG_CODE;
            sel_pc = 1'b1;
        end else if (bus.check_uc) begin
            sel_op = {8'h00, uc_q};
        end
    end

    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        if (read_rise) begin
            entry_d = '0;
            count_d = '0;
        end else if (accept) begin
            if (count_q < 3'd6) begin
                entry_d = {entry_q[19:0], bus.button};
                count_d = count_q + 3'd1;
            end else begin
                count_d = 3'd7;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        is_pc_d  = is_pc_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (any_pulse) begin
                    state_d = CMP;
                    op_d    = sel_op;
                    is_pc_d = sel_pc;
                end
            end
            CMP: begin
                if (is_pc_q) begin
                    result_d = (count_q == 3'd6) && (entry_q == op_q);
                end else begin
                    result_d = (count_q == 3'd4) && (entry_q[15:0] == op_q[15:0]);
                end
                state_d = DONE;
            end
            DONE: begin
                if (any_pulse) begin
                    state_d = CMP;
                    op_d    = sel_op;
                    is_pc_d = sel_pc;
                end else if (read_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            state_q  <= IDLE;
            entry_q  <= '0;
            count_q  <= '0;
            read_q   <= 1'b0;
            uc_q     <= DEFAULT_UC;
            cand_q   <= DEFAULT_UC;
            op_q     <= '0;
            is_pc_q  <= 1'b0;
            result_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            count_q  <= count_d;
            read_q   <= bus.read_input;
            op_q     <= op_d;
            is_pc_q  <= is_pc_d;
            result_q <= result_d;
            if (bus.latch_new && (count_q == 3'd4)) begin
                cand_q <= entry_q[15:0];
            end
            if (bus.store) begin
                uc_q <= cand_q;
            end
        end
    end

    assign bus.data_ready    = (state_q == DONE);
    assign bus.correct_input = (state_q == DONE) & result_q;
    assign bus.validLength   = (count_q == 3'd4);
    assign bus.validLengthPC = (count_q == 3'd6);
    assign bus.fsm_state     = state_q;
endmodule

// File: tb/tb_code_checker.sv
// Directed bench for code_checker: driver tasks push expected compare results,
// a negedge monitor pops and checks them along with result latency.
module tb_code_checker;
    logic hwclk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;

    logic [0:0] exp_q[$];
    int         exp_cyc_q[$];

    code_checker_if bus();

    code_checker #(
        .DEFAULT_UC(16'h1234),
        .PROG_CODE (24'h654321)
    ) dut (
        .hwclk(hwclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial begin
        hwclk = 1'b0;
        forever #5 hwclk = ~hwclk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge hwclk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        bus.button       = d;
        bus.button_valid = 1'b1;
        tick();
        bus.button_valid = 1'b0;
    endtask

    task automatic rise_read();
        bus.read_input = 1'b0;
        tick();
        bus.read_input = 1'b1;
        tick();
    endtask

    task automatic enter4(input logic [15:0] code);
        rise_read();
        for (int i = 3; i >= 0; i--) press(code[i*4 +: 4]);
    endtask

    task automatic wait_result();
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick();
        check("result_timeout", exp_q.size(), 0);
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    task automatic pulse(input logic uc, input logic pc, input logic ln, input logic cm,
                         input logic st, input logic has_exp, input logic expv);
        bus.check_uc    = uc;
        bus.check_pc    = pc;
        bus.latch_new   = ln;
        bus.check_match = cm;
        bus.store       = st;
        if (has_exp) begin
            exp_q.push_back(expv);
            exp_cyc_q.push_back(cyc + 2);
        end
        tick();
        bus.check_uc    = 1'b0;
        bus.check_pc    = 1'b0;
        bus.latch_new   = 1'b0;
        bus.check_match = 1'b0;
        bus.store       = 1'b0;
        if (has_exp) wait_result();
    endtask

    // Monitor: pops one expectation per rising data_ready.
    initial begin
        logic dr_prev;
        logic [0:0] e;
        int c;
        dr_prev = 1'b0;
        forever begin
            @(negedge hwclk);
            if (bus.data_ready && !dr_prev) begin
                check("result_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    check("correct_input", bus.correct_input, e);
                    check("latency_cycle", cyc, c);
                end
            end
            if (!bus.data_ready) check("correct_low_idle", bus.correct_input, 0);
            dr_prev = bus.data_ready;
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus.button = 4'd0;
        bus.button_valid = 1'b0;
        bus.read_input = 1'b0;
        bus.check_uc = 1'b0;
        bus.check_pc = 1'b0;
        bus.latch_new = 1'b0;
        bus.check_match = 1'b0;
        bus.store = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_data_ready", bus.data_ready, 0);
        check("rst_correct", bus.correct_input, 0);
        check("rst_validLength", bus.validLength, 0);
        check("rst_validLengthPC", bus.validLengthPC, 0);
        check("rst_fsm_state", bus.fsm_state, 0);

        // Default user code
        enter4(16'h1234);
        check("vl_1234", bus.validLength, 1);
        check("vlpc_1234", bus.validLengthPC, 0);
        pulse(1, 0, 0, 0, 0, 1, 1);
        enter4(16'h1235);
        pulse(1, 0, 0, 0, 0, 1, 0);
        rise_read();
        press(1); press(2); press(3);
        check("vl_3digits", bus.validLength, 0);
        pulse(1, 0, 0, 0, 0, 1, 0);

        // Programming code
        rise_read();
        press(6); press(5); press(4); press(3); press(2); press(1);
        check("vlpc_6digits", bus.validLengthPC, 1);
        check("vl_6digits", bus.validLength, 0);
        pulse(0, 1, 0, 0, 0, 1, 1);
        pulse(1, 0, 0, 0, 0, 1, 0);
        rise_read();
        press(6); press(5); press(4); press(3); press(2); press(0);
        pulse(0, 1, 0, 0, 0, 1, 0);

        // Overflow on 7th digit
        rise_read();
        press(1); press(2); press(3); press(4); press(5); press(6); press(0);
        check("vl_overflow", bus.validLength, 0);
        check("vlpc_overflow", bus.validLengthPC, 0);
        pulse(1, 0, 0, 0, 0, 1, 0);

        // Keys 7..15 are ignored
        rise_read();
        press(1); press(2); press(7); press(9); press(3); press(15); press(4);
        check("vl_ignored_keys", bus.validLength, 1);
        pulse(1, 0, 0, 0, 0, 1, 1);

        // Digit strobed on the read_input rise cycle is dropped
        bus.read_input = 1'b0;
        tick();
        bus.read_input = 1'b1;
        press(1);
        press(1); press(2); press(3); press(4);
        check("vl_drop_on_rise", bus.validLength, 1);
        pulse(1, 0, 0, 0, 0, 1, 1);

        // Priority: check_pc wins over check_uc
        pulse(1, 1, 0, 0, 0, 1, 0);
        rise_read();
        press(6); press(5); press(4); press(3); press(2); press(1);
        pulse(1, 1, 0, 0, 0, 1, 1);

        // Reprogram to 5501
        enter4(16'h5501);
        pulse(0, 0, 1, 0, 0, 0, 0);
        enter4(16'h5501);
        pulse(0, 0, 0, 1, 0, 1, 1);
        pulse(0, 0, 0, 0, 1, 0, 0);
        enter4(16'h5501);
        pulse(1, 0, 0, 0, 0, 1, 1);
        enter4(16'h1234);
        pulse(1, 0, 0, 0, 0, 1, 0);

        // check_uc and store in the same cycle see the old code
        enter4(16'h2222);
        pulse(0, 0, 1, 0, 0, 0, 0);
        enter4(16'h5501);
        pulse(1, 0, 0, 0, 1, 1, 1);
        pulse(1, 0, 0, 0, 0, 1, 0);

        // Pulse during CMP ignored, result held, cleared by read_input rise
        enter4(16'h2222);
        bus.check_uc = 1'b1;
        exp_q.push_back(1'b1);
        exp_cyc_q.push_back(cyc + 2);
        tick();
        bus.check_uc = 1'b0;
        bus.check_pc = 1'b1;
        tick();
        bus.check_pc = 1'b0;
        wait_result();
        tick(); tick(); tick();
        check("held_data_ready", bus.data_ready, 1);
        check("held_correct", bus.correct_input, 1);
        rise_read();
        check("done_exit_on_rise", bus.data_ready, 0);

        // Reset mid-compare aborts and restores defaults
        enter4(16'h2222);
        pulse(1, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("abort_data_ready", bus.data_ready, 0);
            tick();
        end
        check("abort_validLength", bus.validLength, 0);
        enter4(16'h1234);
        pulse(1, 0, 0, 0, 0, 1, 1);

        // latch_new ignored unless 4 digits; candidate back to default
        rise_read();
        press(6); press(6); press(6);
        pulse(0, 0, 1, 0, 0, 0, 0);
        enter4(16'h1234);
        pulse(0, 0, 0, 1, 0, 1, 1);

        tick();
        tick();
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/code_checker.md
CODE_CHECKER -- requirements
Module: code_checker

Interface
REQ-001 SHALL have parameter DEFAULT_UC, 16'h1234, power-on user code (4 digits, 4 bits each, MSD first).
REQ-002 SHALL have parameter PROG_CODE, 24'h654321, fixed 6-digit programming code, MSD first.
REQ-003 SHALL have port hwclk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port button  input  4  key value; digits 0-6, 7/8/9 are controller commands.
REQ-006 SHALL have port button_valid  input  1  one-cycle strobe qualifying button.
REQ-007 SHALL have port read_input  input  1  from controller; high = entry buffer accepts digits.
REQ-008 SHALL have port check_uc  input  1  pulse; compare entry against stored user code.
REQ-009 SHALL have port check_pc  input  1  pulse; compare entry against PROG_CODE.
REQ-010 SHALL have port latch_new  input  1  pulse; copy entry into candidate register.
REQ-011 SHALL have port check_match  input  1  pulse; compare entry against candidate.
REQ-012 SHALL have port store  input  1  pulse; write candidate into user code register.
REQ-013 SHALL have port data_ready  output  1  compare result valid.
REQ-014 SHALL have port correct_input  output  1  compare result; meaningful only while data_ready.
REQ-015 SHALL have port validLength  output  1  entry holds exactly 4 digits.
REQ-016 SHALL have port validLengthPC  output  1  entry holds exactly 6 digits.

Function
REQ-017 SHALL keep a 6-digit entry shift buffer and 3-bit count; an accepted digit shifts in at LSD, count increments.
REQ-018 SHALL accept a digit only when button_valid=1, read_input=1, button<=6; values 7-15 SHALL be ignored.
REQ-019 SHALL saturate count at 7 (overflow) on a 7th accepted digit; buffer content then unchanged; validLength and validLengthPC both 0 while count=7.
REQ-020 SHALL clear buffer and count in the cycle after a 0->1 transition of read_input (registered edge detect); a digit strobed in that same cycle SHALL be dropped.
REQ-021 SHALL drive validLength=(count==4) and validLengthPC=(count==6) combinationally from registered count.
REQ-022 SHALL implement compare FSM: IDLE, CMP, DONE.
REQ-023 IDLE: on any compare pulse latch operand select, go CMP; priority check_pc > check_uc > check_match when simultaneous.
REQ-024 CMP: register equality of entry (low 4 digits if count==4 for UC/match, all 6 for PC) against operand; mismatch in count (4 for UC/match, 6 for PC) SHALL force result 0; go DONE.
REQ-025 DONE: data_ready=1 and correct_input=registered result; held until read_input rises (0->1 edge) or another compare pulse arrives, then IDLE (new pulse restarts at CMP directly).
REQ-026 Latency: compare pulse in cycle N -> data_ready=1 in cycle N+2.
REQ-027 Compare pulses arriving in CMP SHALL be ignored.
REQ-028 latch_new SHALL copy low 4 entry digits into candidate in the next cycle regardless of FSM state; ignored unless count==4.
REQ-029 store SHALL write candidate into user code register next cycle regardless of FSM state; a check_uc in the same cycle SHALL compare against the old code.
REQ-030 correct_input SHALL be 0 whenever data_ready=0.

Reset
REQ-031 On rst=1 at a clock edge: user code=DEFAULT_UC, candidate=DEFAULT_UC, entry cleared, count=0, FSM=IDLE, data_ready=0, correct_input=0, validLength=0, validLengthPC=0.
REQ-032 rst mid-compare SHALL abort; no result asserted; rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-033 read_input rise, digits 1,2,3,4, check_uc at N -> validLength=1 before pulse; data_ready=1 and correct_input=1 at N+2.
REQ-034 digits 6,5,4,3,2,1 then check_pc -> validLengthPC=1, correct_input=1; same with digits 6,5,4,3,2,0 -> correct_input=0.
REQ-035 7 digits entered -> validLength=0, validLengthPC=0; check_uc -> data_ready=1, correct_input=0.
REQ-036 reprogram: enter 5,5,0,1, latch_new; re-enter 5,5,0,1, check_match -> correct_input=1; store; enter 5,5,0,1, check_uc -> correct_input=1; 1,2,3,4 -> 0.
REQ-037 check_uc and store same cycle with old-code entry -> correct_input=1; subsequent check_uc with old code -> 0.
REQ-038 rst asserted cycle after check_uc -> data_ready never asserts; user code back to DEFAULT_UC.
